// File: rtl/cs_result_buffer_if.sv
// Result drain port of the CS result buffer: FWFT head data with valid/ready handshake.
interface cs_result_buffer_if #(
  parameter int unsigned DW = 10
);
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cs_result_buffer.sv
// CS result buffer: drops warm-up Y samples, queues valid results in a FWFT FIFO,
// drains them over a valid/ready port; tracks overflow and accepted-sample count.
module cs_result_buffer #(
  parameter int unsigned DW     = 10,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WARMUP = 9,
  parameter int unsigned CW     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          Y,
  input  logic                   en,
  cs_result_buffer_if.master     bus,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [CW-1:0]          sample_cnt
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned WUW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  logic [DW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [WUW-1:0] wu_cnt_q, wu_cnt_d;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           armed, push, pop, wr_en, drop;

  always_comb begin
    armed    = (wu_cnt_q == WUW'(WARMUP));
    empty    = (level_q == '0);
    full     = (level_q == LW'(DEPTH));
    pop      = ~empty & bus.out_ready;
    push     = armed & en;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;

    wu_cnt_d = armed ? wu_cnt_q : wu_cnt_q + WUW'(1);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    level_d  = level_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    ovf_d = drop | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      wu_cnt_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      wu_cnt_q <= wu_cnt_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage deliberately has no reset; emptiness is tracked by level alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= Y;
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign sample_cnt    = cnt_q;

endmodule
